// File: rtl/fp_vector_checker.sv
// rtl/fp_vector_checker.sv - ROM-driven self-checking vector engine for floating-point ALU units
// Streams {a, b, expected} vectors into a DUT, compares delayed results, counts and captures the first failure.
module fp_vector_checker #(
    parameter int WIDTH        = 32,
    parameter int FLAG_W       = 3,
    parameter int N_TESTS      = 1024,
    parameter int ADDR_W       = 10,
    parameter int LATENCY      = 0,
    parameter int STOP_ON_FAIL = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic [ADDR_W-1:0]         vec_addr,
    input  logic [3*WIDTH+FLAG_W-1:0] vec_data,
    output logic [WIDTH-1:0]          a_operand,
    output logic [WIDTH-1:0]          b_operand,
    input  logic [WIDTH-1:0]          dut_result,
    input  logic [FLAG_W-1:0]         dut_flags,
    output logic                      busy,
    output logic                      done,
    output logic [31:0]               pass_count,
    output logic [31:0]               fail_count,
    output logic [31:0]               test_count,
    output logic                      fail_seen,
    output logic [ADDR_W-1:0]         fail_index,
    output logic [WIDTH+FLAG_W-1:0]   fail_expected,
    output logic [WIDTH+FLAG_W-1:0]   fail_obtained
);
    localparam int EW = WIDTH + FLAG_W;
    localparam int DW = 3*WIDTH + FLAG_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_TESTS - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              s1_valid_q, s1_valid_d;
    logic [ADDR_W-1:0] s1_idx_q, s1_idx_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
    logic [LATENCY:0]  pv_q, pv_d;
    logic [EW-1:0]     pexp_q [LATENCY+1];
    logic [EW-1:0]     pexp_d [LATENCY+1];
    logic [ADDR_W-1:0] pidx_q [LATENCY+1];
    logic [ADDR_W-1:0] pidx_d [LATENCY+1];
    logic [31:0]       pass_q, pass_d, fail_q, fail_d, test_q, test_d;
    logic              fseen_q, fseen_d;
    logic [ADDR_W-1:0] findex_q, findex_d;
    logic [EW-1:0]     fexp_q, fexp_d, fobt_q, fobt_d;

    logic [EW-1:0]     obtained;
    logic              cmp_valid;
    logic              mismatch;

    assign obtained  = {dut_result, dut_flags};
    assign cmp_valid = pv_q[LATENCY];
    assign mismatch  = cmp_valid && (obtained != pexp_q[LATENCY]);

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        a_d        = a_q;
        b_d        = b_q;
        pass_d     = pass_q;
        fail_d     = fail_q;
        test_d     = test_q;
        fseen_d    = fseen_q;
        findex_d   = findex_q;
        fexp_d     = fexp_q;
        fobt_d     = fobt_q;
        pexp_d     = pexp_q;
        pidx_d     = pidx_q;

        // Issue and shift: ROM data of the previous cycle's address lands in stage 1
        s1_valid_d = (state_q == S_RUN);
        s1_idx_d   = addr_q;
        if (s1_valid_q) begin
            a_d = vec_data[DW-1 -: WIDTH];
            b_d = vec_data[DW-WIDTH-1 -: WIDTH];
        end
        pv_d[0]   = s1_valid_q;
        pexp_d[0] = vec_data[EW-1:0];
        pidx_d[0] = s1_idx_q;
        for (int k = 1; k <= LATENCY; k++) begin
            pv_d[k]   = pv_q[k-1];
            pexp_d[k] = pexp_q[k-1];
            pidx_d[k] = pidx_q[k-1];
        end

        if (cmp_valid) begin
            test_d = sat_inc(test_q);
            if (mismatch) begin
                fail_d = sat_inc(fail_q);
                if (!fseen_q) begin
                    fseen_d  = 1'b1;
                    findex_d = pidx_q[LATENCY];
                    fexp_d   = pexp_q[LATENCY];
                    fobt_d   = obtained;
                end
            end else begin
                pass_d = sat_inc(pass_q);
            end
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d    = S_RUN;
                    addr_d     = '0;
                    pass_d     = '0;
                    fail_d     = '0;
                    test_d     = '0;
                    fseen_d    = 1'b0;
                    findex_d   = '0;
                    fexp_d     = '0;
                    fobt_d     = '0;
                    s1_valid_d = 1'b0;
                    pv_d       = '0;
                end
            end
            S_RUN: begin
                if (addr_q == LAST_ADDR) state_d = S_DRAIN;
                else                     addr_d  = addr_q + 1'b1;
            end
            S_DRAIN: begin
                if (!s1_valid_d && (pv_d == '0)) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase

        // Stop drops everything still in flight so test_count ends at the failing index + 1
        if ((STOP_ON_FAIL != 0) && mismatch) begin
            state_d    = S_DONE;
            s1_valid_d = 1'b0;
            pv_d       = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            s1_valid_q <= 1'b0;
            s1_idx_q   <= '0;
            a_q        <= '0;
            b_q        <= '0;
            pv_q       <= '0;
            pexp_q     <= '{default: '0};
            pidx_q     <= '{default: '0};
            pass_q     <= '0;
            fail_q     <= '0;
            test_q     <= '0;
            fseen_q    <= 1'b0;
            findex_q   <= '0;
            fexp_q     <= '0;
            fobt_q     <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            s1_valid_q <= s1_valid_d;
            s1_idx_q   <= s1_idx_d;
            a_q        <= a_d;
            b_q        <= b_d;
            pv_q       <= pv_d;
            pexp_q     <= pexp_d;
            pidx_q     <= pidx_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            test_q     <= test_d;
            fseen_q    <= fseen_d;
            findex_q   <= findex_d;
            fexp_q     <= fexp_d;
            fobt_q     <= fobt_d;
        end
    end

    assign vec_addr      = addr_q;
    assign a_operand     = a_q;
    assign b_operand     = b_q;
    assign busy          = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done          = (state_q == S_DONE);
    assign pass_count    = pass_q;
    assign fail_count    = fail_q;
    assign test_count    = test_q;
    assign fail_seen     = fseen_q;
    assign fail_index    = findex_q;
    assign fail_expected = fexp_q;
    assign fail_obtained = fobt_q;

endmodule

// File: tb/tb_fp_vector_checker.sv
// tb/tb_fp_vector_checker.sv - self-checking bench for fp_vector_checker with a toy FP multiplier as DUT
module tb_fp_vector_checker;
    localparam int W  = 32;
    localparam int FW = 3;
    localparam int DW = 3*W + FW;
    localparam int EW = W + FW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Truncating single-precision multiplier; returns {result, flags{exc,ovf,unf}}
    function automatic logic [34:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        int          e;
        logic [47:0] p;
        logic [22:0] m;
        s = a[31] ^ b[31];
        if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return {32'h7FC0_0000, 3'b100};
        if (a[30:23] == 8'h00 || b[30:23] == 8'h00) return {s, 31'd0, 3'b000};
        p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) begin
            m = p[46:24];
            e = e + 1;
        end else begin
            m = p[45:23];
        end
        if (e >= 255) return {s, 8'hFF, 23'd0, 3'b010};
        if (e <= 0)   return {s, 31'd0, 3'b001};
        return {s, e[7:0], m, 3'b000};
    endfunction

    // ---------------- u0: single vector, combinational DUT ----------------
    logic           start0 = 1'b0;
    logic [0:0]     addr0;
    logic [DW-1:0]  rom0 = '0;
    logic [DW-1:0]  rd0;
    logic [W-1:0]   a0, b0;
    logic [34:0]    m0;
    logic           busy0, done0, fs0;
    logic [31:0]    pc0, fc0, tc0;
    logic [0:0]     fi0;
    logic [EW-1:0]  fe0, fo0;

    always_ff @(posedge clk) rd0 <= (addr0 == 1'b0) ? rom0 : '0;
    assign m0 = fmul(a0, b0);

    fp_vector_checker #(.WIDTH(W), .FLAG_W(FW), .N_TESTS(1), .ADDR_W(1), .LATENCY(0), .STOP_ON_FAIL(0)) u0 (
        .clk(clk), .rst(rst), .start(start0), .vec_addr(addr0), .vec_data(rd0),
        .a_operand(a0), .b_operand(b0), .dut_result(m0[34:3]), .dut_flags(m0[2:0]),
        .busy(busy0), .done(done0), .pass_count(pc0), .fail_count(fc0), .test_count(tc0),
        .fail_seen(fs0), .fail_index(fi0), .fail_expected(fe0), .fail_obtained(fo0));

    // ---------------- u1/u2: 8 vectors, 3-stage registered DUT ----------------
    logic           start8 = 1'b0;
    logic [DW-1:0]  rom8 [8];
    logic [2:0]     addr1, addr2;
    logic [DW-1:0]  rd1, rd2;
    logic [W-1:0]   a1, b1, a2, b2;
    logic [34:0]    p1 [3];
    logic [34:0]    p2 [3];
    logic           busy1, done1, fs1, busy2, done2, fs2;
    logic [31:0]    pc1, fc1, tc1, pc2, fc2, tc2;
    logic [2:0]     fi1, fi2;
    logic [EW-1:0]  fe1, fo1, fe2, fo2;

    always_ff @(posedge clk) begin
        rd1   <= rom8[addr1];
        rd2   <= rom8[addr2];
        p1[0] <= fmul(a1, b1);
        p1[1] <= p1[0];
        p1[2] <= p1[1];
        p2[0] <= fmul(a2, b2);
        p2[1] <= p2[0];
        p2[2] <= p2[1];
    end

    fp_vector_checker #(.WIDTH(W), .FLAG_W(FW), .N_TESTS(8), .ADDR_W(3), .LATENCY(3), .STOP_ON_FAIL(0)) u1 (
        .clk(clk), .rst(rst), .start(start8), .vec_addr(addr1), .vec_data(rd1),
        .a_operand(a1), .b_operand(b1), .dut_result(p1[2][34:3]), .dut_flags(p1[2][2:0]),
        .busy(busy1), .done(done1), .pass_count(pc1), .fail_count(fc1), .test_count(tc1),
        .fail_seen(fs1), .fail_index(fi1), .fail_expected(fe1), .fail_obtained(fo1));

    fp_vector_checker #(.WIDTH(W), .FLAG_W(FW), .N_TESTS(8), .ADDR_W(3), .LATENCY(3), .STOP_ON_FAIL(1)) u2 (
        .clk(clk), .rst(rst), .start(start8), .vec_addr(addr2), .vec_data(rd2),
        .a_operand(a2), .b_operand(b2), .dut_result(p2[2][34:3]), .dut_flags(p2[2][2:0]),
        .busy(busy2), .done(done2), .pass_count(pc2), .fail_count(fc2), .test_count(tc2),
        .fail_seen(fs2), .fail_index(fi2), .fail_expected(fe2), .fail_obtained(fo2));

    logic any0, any1, any2;
    assign any0 = |{addr0, a0, b0, busy0, done0, pc0, fc0, tc0, fs0, fi0, fe0, fo0};
    assign any1 = |{addr1, a1, b1, busy1, done1, pc1, fc1, tc1, fs1, fi1, fe1, fo1};
    assign any2 = |{addr2, a2, b2, busy2, done2, pc2, fc2, tc2, fs2, fi2, fe2, fo2};

    // ---------------- run helper ----------------
    int          cur_sel;
    logic        busy_s, done_s;
    logic [31:0] tc_s;
    int          d_cyc, d2_cyc, b_first, b_last;
    logic [31:0] tc_at1;

    always_comb begin
        busy_s = busy1;
        done_s = done1;
        tc_s   = tc1;
        if (cur_sel == 0) begin
            busy_s = busy0;
            done_s = done0;
            tc_s   = tc0;
        end
    end

    task automatic set_start(input logic v);
        if (cur_sel == 0) start0 = v;
        else              start8 = v;
    endtask

    // Cycle c is the c-th cycle after the edge that samples start; sampled at negedge.
    task automatic run(input int pulse_at);
        d_cyc = -1; d2_cyc = -1; b_first = -1; b_last = -1; tc_at1 = '1;
        @(negedge clk);
        set_start(1'b1);
        for (int c = 1; c <= 40 && d_cyc < 0; c++) begin
            @(negedge clk);
            set_start(c == pulse_at);
            if (c == 1) tc_at1 = tc_s;
            if (busy_s) begin
                if (b_first < 0) b_first = c;
                b_last = c;
            end
            if (done2 && d2_cyc < 0) d2_cyc = c;
            if (done_s) d_cyc = c;
        end
        if (d_cyc < 0) chk("run_timeout", 64'd0, 64'd1);
    endtask

    // Reference: plain walk over the ROM with the multiplier's outputs
    int          r_pc, r_fc, r_tc, r_fi;
    logic [34:0] r_fe, r_fo;
    task automatic ref8(input logic stop);
        r_pc = 0; r_fc = 0; r_tc = 0; r_fi = 0; r_fe = '0; r_fo = '0;
        for (int i = 0; i < 8; i++) begin
            logic [34:0] ob, ex;
            ob = fmul(rom8[i][98:67], rom8[i][66:35]);
            ex = rom8[i][34:0];
            r_tc++;
            if (ob == ex) begin
                r_pc++;
            end else begin
                if (r_fc == 0) begin
                    r_fi = i;
                    r_fe = ex;
                    r_fo = ob;
                end
                r_fc++;
                if (stop) break;
            end
        end
    endtask

    task automatic check8();
        ref8(1'b0);
        chk("u1_done_cycle", d_cyc, 14);
        chk("u1_pass", pc1, r_pc);
        chk("u1_fail", fc1, r_fc);
        chk("u1_test", tc1, r_tc);
        chk("u1_seen", fs1, r_fc != 0);
        chk("u1_index", fi1, r_fi);
        chk("u1_expected", fe1, r_fe);
        chk("u1_obtained", fo1, r_fo);
        ref8(1'b1);
        chk("u2_done_cycle", d2_cyc, (r_fc != 0) ? r_fi + 7 : 14);
        chk("u2_pass", pc2, r_pc);
        chk("u2_fail", fc2, r_fc);
        chk("u2_test", tc2, r_tc);
        chk("u2_index", fi2, r_fi);
    endtask

    typedef struct {
        logic [31:0] a, b, er;
        logic [2:0]  ef;
        logic        pass;
        logic [34:0] obt;
    } vec_t;

    vec_t tbl [7];

    initial begin
        tbl[0] = '{32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000, 3'b000, 1'b1, {32'h4040_0000, 3'b000}};
        tbl[1] = '{32'h7F7F_FFFF, 32'h3F80_0000, 32'h7F80_0000, 3'b000, 1'b0, {32'h7F7F_FFFF, 3'b000}};
        tbl[2] = '{32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000, 3'b000, 1'b0, {32'h7F80_0000, 3'b010}};
        tbl[3] = '{32'h8000_0000, 32'h3F80_0000, 32'h0000_0000, 3'b000, 1'b0, {32'h8000_0000, 3'b000}};
        tbl[4] = '{32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 3'b100, 1'b1, {32'h7FC0_0000, 3'b100}};
        tbl[5] = '{32'hC040_0000, 32'h3F00_0000, 32'hBFC0_0000, 3'b000, 1'b1, {32'hBFC0_0000, 3'b000}};
        tbl[6] = '{32'h3F80_0000, 32'h7FC0_0000, 32'h7FC0_0001, 3'b100, 1'b0, {32'h7FC0_0000, 3'b100}};

        for (int i = 0; i < 8; i++) rom8[i] = '0;
        cur_sel = 0;
        repeat (3) @(negedge clk);
        chk("reset_u0_outputs", any0, 0);
        chk("reset_u1_outputs", any1, 0);
        chk("reset_u2_outputs", any2, 0);
        rst = 1'b0;

        // single-vector table on the combinational DUT
        cur_sel = 0;
        for (int t = 0; t < 7; t++) begin
            rom0 = {tbl[t].a, tbl[t].b, tbl[t].er, tbl[t].ef};
            run(0);
            chk($sformatf("u0_done_cycle_%0d", t), d_cyc, 4);
            chk($sformatf("u0_busy_span_%0d", t), {b_first, b_last}, {32'd1, 32'd3});
            chk($sformatf("u0_pass_%0d", t), pc0, tbl[t].pass ? 1 : 0);
            chk($sformatf("u0_fail_%0d", t), fc0, tbl[t].pass ? 0 : 1);
            chk($sformatf("u0_test_%0d", t), tc0, 1);
            chk($sformatf("u0_seen_%0d", t), fs0, !tbl[t].pass);
            if (!tbl[t].pass) begin
                chk($sformatf("u0_index_%0d", t), fi0, 0);
                chk($sformatf("u0_expected_%0d", t), fe0, {tbl[t].er, tbl[t].ef});
                chk($sformatf("u0_obtained_%0d", t), fo0, tbl[t].obt);
            end
        end

        // 8 vectors, vector 5 stores a wrong expected result
        cur_sel = 1;
        for (int i = 0; i < 8; i++) begin
            logic [31:0] a, b;
            a = 32'h3F80_0000 + (i << 20);
            b = 32'h4000_0000 + (i << 19);
            rom8[i] = {a, b, fmul(a, b)};
        end
        rom8[5] = {32'h7F7F_FFFF, 32'h3F80_0000, 32'h7F80_0000, 3'b000};
        run(0);
        chk("v5_busy_span", {b_first, b_last}, {32'd1, 32'd13});
        chk("v5_u1_done", d_cyc, 14);
        chk("v5_u1_pass", pc1, 7);
        chk("v5_u1_fail", fc1, 1);
        chk("v5_u1_index", fi1, 5);
        chk("v5_u1_expected", fe1, {32'h7F80_0000, 3'b000});
        chk("v5_u1_obtained", fo1, {32'h7F7F_FFFF, 3'b000});
        chk("v5_u2_done", d2_cyc, 12);
        chk("v5_u2_test", tc2, 6);
        chk("v5_u2_pass", pc2, 5);
        chk("v5_u2_fail", fc2, 1);
        check8();

        // all correct, with start pulsed while busy
        rom8[5] = {32'h7F7F_FFFF, 32'h3F80_0000, fmul(32'h7F7F_FFFF, 32'h3F80_0000)};
        run(5);
        chk("restart_cleared", tc_at1, 0);
        chk("busy_start_done", d_cyc, 14);
        chk("busy_start_pass", pc1, 8);
        chk("busy_start_test", tc1, 8);
        chk("hold_a_operand", a1, rom8[7][98:67]);
        check8();
        run(0);
        chk("rerun_pass", pc1, 8);
        chk("rerun_fail", fc1, 0);

        // randomized ROM contents with sporadic corruption
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 8; i++) begin
                logic [31:0] a, b;
                int bitn;
                a = $urandom;
                b = $urandom;
                rom8[i] = {a, b, fmul(a, b)};
                bitn = $urandom_range(34);
                if (r > 0 && $urandom_range(3) == 0) rom8[i][bitn] = ~rom8[i][bitn];
            end
            run(0);
            check8();
        end

        // reset in cycle 4 of a run
        @(negedge clk);
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrun_busy_before", busy1, 1);
        rst = 1'b1;
        #1;
        chk("midrun_rst_u1", any1, 0);
        chk("midrun_rst_u2", any2, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("after_rst_idle", {busy1, done1}, 2'b00);
        chk("after_rst_counts", tc1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
